// File: rtl/up_down_sweep_ctrl_if.sv
// Control bus between the sweep controller and an up/down/load counter.
//   en   : counter enable
//   up   : count direction, 1 = up
//   load : parallel load strobe
//   d    : parallel load value
//   q    : counter output, fed back to the controller
// master = controller side, slave = counter side.
interface up_down_sweep_ctrl_if #(
  parameter int N = 4
);
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] d;
  logic [N-1:0] q;

  modport master (output en, up, load, d, input q);
  modport slave  (input en, up, load, d, output q);
endinterface

// File: rtl/up_down_sweep_ctrl.sv
// Sweep controller: on start, loads lo into the counter, counts up to hi,
// pauses PAUSE cycles, counts back down to lo, pauses PAUSE cycles, and
// repeats for the programmed number of sweeps, producing triangle patterns.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a run (only looked at in IDLE)
//   lo, hi, reps     : bounds and sweep count, captured on accepted start
//   cnt (master)     : en/up/load/d to the counter, q back from it
//   busy             : high in every state but IDLE
//   done             : one-cycle pulse at normal completion
//   err              : sticky error (lo > hi, or watchdog), cleared by start
//
// Optional feature macro: SWEEP_WATCHDOG_EN
//   When defined, a RISE/FALL dwell of 2^N+1 cycles aborts the run to IDLE
//   with err set and no done pulse.
module up_down_sweep_ctrl #(
  parameter int N     = 4,
  parameter int PAUSE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N-1:0]           lo,
  input  logic [N-1:0]           hi,
  input  logic [7:0]             reps,
  up_down_sweep_ctrl_if.master   cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RISE, S_HOLD_TOP, S_FALL, S_HOLD_BOT, S_DONE
  } state_t;

  localparam int PW = (PAUSE < 2) ? 1 : $clog2(PAUSE);

  state_t         state, state_nx;
  logic [N-1:0]   lo_r, hi_r;
  logic [7:0]     reps_r;
  logic [PW-1:0]  pcnt;
  logic [N-1:0]   hi_m1, lo_p1;
  logic           flat, last, pause_end, accept, reject, wd_trip;

  // Only consulted in RISE (hi_r > lo_r >= 0) and FALL (lo_r < hi_r <= max),
  // so neither can wrap where it matters.
  assign hi_m1     = hi_r - N'(1);
  assign lo_p1     = lo_r + N'(1);
  assign flat      = (lo_r == hi_r);
  assign last      = (reps_r <= 8'd1);
  assign pause_end = (pcnt == PW'(PAUSE - 1));
  assign cnt.d     = lo_r;

`ifdef SWEEP_WATCHDOG_EN
  localparam int WDW = $clog2((2 ** N) + 2);
  logic [WDW-1:0] wd_cnt;
  // wd_cnt holds cycles already spent in RISE/FALL, so the trip fires on the
  // (2^N+1)-th consecutive cycle; a healthy sweep needs at most 2^N-1.
  assign wd_trip = ((state == S_RISE) || (state == S_FALL)) &&
                   (wd_cnt == WDW'(2 ** N));
`else
  assign wd_trip = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            accept   = 1'b1;
            state_nx = S_LOAD;
          end else begin
            reject   = 1'b1;
          end
        end
      end
      S_LOAD:     state_nx = flat ? S_HOLD_TOP : S_RISE;
      S_RISE:     if (cnt.q == hi_m1) state_nx = S_HOLD_TOP;
      S_HOLD_TOP: begin
        // A flat run has nothing to count down, so take the FALL exit here.
        if (pause_end)
          state_nx = !flat ? S_FALL : (last ? S_DONE : S_HOLD_BOT);
      end
      S_FALL:     if (cnt.q == lo_p1) state_nx = last ? S_DONE : S_HOLD_BOT;
      S_HOLD_BOT: begin
        // Flat runs bypass RISE too, otherwise they would wait forever.
        if (pause_end) state_nx = flat ? S_HOLD_TOP : S_RISE;
      end
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    if (wd_trip) state_nx = S_IDLE;
  end

  // Moore decode of the state register.
  always_comb begin
    cnt.en   = 1'b0;
    cnt.up   = 1'b1;
    cnt.load = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    unique case (state)
      S_LOAD:     cnt.load = 1'b1;
      S_RISE:     cnt.en   = 1'b1;
      S_FALL:     begin cnt.en = 1'b1; cnt.up = 1'b0; end
      S_HOLD_BOT: cnt.up   = 1'b0;
      S_DONE:     done     = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      lo_r   <= '0;
      hi_r   <= '0;
      reps_r <= '0;
      pcnt   <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lo_r   <= lo;
        hi_r   <= hi;
        reps_r <= (reps == 8'd0) ? 8'd1 : reps;
        err    <= 1'b0;
      end
      if (reject || wd_trip) err <= 1'b1;
      // Pause counter restarts on every state change.
      if (state_nx != state)
        pcnt <= '0;
      else if ((state == S_HOLD_TOP) || (state == S_HOLD_BOT))
        pcnt <= pcnt + PW'(1);
      if ((state == S_HOLD_BOT) && pause_end)
        reps_r <= reps_r - 8'd1;
    end
  end

`ifdef SWEEP_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset)
      wd_cnt <= '0;
    else if (state_nx != state)
      wd_cnt <= '0;
    else if ((state == S_RISE) || (state == S_FALL))
      wd_cnt <= wd_cnt + WDW'(1);
  end
`endif

endmodule

// File: doc/up_down_sweep_ctrl.md
# up_down_sweep_ctrl

Sweep controller that drives the control side of the up/down/load counter (`en`, `up`, `load`, `D`) and watches its `Q` output. On `start` it loads a lower bound, counts up to an upper bound, pauses, counts back down, and repeats for a programmed number of sweeps. It lets the rest of the design and the benches generate bounded triangle count patterns without hand-sequencing the counter's inputs.

## Interface
- `N`, 4: counter width; must match the controlled counter.
- `PAUSE`, 2: idle cycles at each turning point (≥1).
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `lo`  in  N  lower bound; captured on accepted `start`.
- `hi`  in  N  upper bound; captured on accepted `start`.
- `reps`  in  8  number of up/down sweeps; 0 is treated as 1; captured on `start`.
- `q`  in  N  counter output `Q`.
- `en`  out  1  counter enable.
- `up`  out  1  counter direction; 1 = up.
- `load`  out  1  counter parallel load.
- `d`  out  N  counter load value; always equals captured `lo`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at normal completion.
- `err`  out  1  sticky run error; cleared on the next accepted `start`.

## Operation
- Reset: state IDLE, `lo_r = hi_r = 0`, `reps_r = 0`, `en = 0`, `up = 1`, `load = 0`, `d = 0`, `busy = 0`, `done = 0`, `err = 0`.
- `en`, `up`, `load` and `done` are Moore outputs of the state register. No output depends combinationally on `q`.
- IDLE (`en = 0`, `up = 1`)
  - `start = 1` with `lo ≤ hi`: capture `lo`, `hi` and `reps`, clear `err`, go to LOAD.
  - `start = 1` with `lo > hi`: set `err` and stay in IDLE.
- LOAD (`load = 1`): exactly one cycle.
  - Go to RISE, or to HOLD_TOP if `lo_r == hi_r`.
- RISE (`en = 1`, `up = 1`): on an edge where `q == hi_r - 1`, go to HOLD_TOP. The counter reaches `hi_r` on that same edge.
- HOLD_TOP (`en = 0`, `up = 1`): PAUSE cycles, then go to FALL. If `lo_r == hi_r`, skip FALL and apply the FALL exit rule directly.
- FALL (`en = 1`, `up = 0`): on an edge where `q == lo_r + 1`, leave FALL.
  - Last sweep: go to DONE.
  - Otherwise: go to HOLD_BOT.
- HOLD_BOT (`en = 0`, `up = 0`): PAUSE cycles, decrement the sweep count, then go to RISE.
- DONE (`done = 1`): one cycle, then IDLE.
- `start` outside IDLE is ignored. `reset` mid-run forces IDLE on that edge and drops `en` and `load` immediately.
- Bound comparisons are N-bit unsigned. `hi_r - 1` and `lo_r + 1` are only evaluated in states where they cannot wrap.

## Timing
- With m = `hi - lo` and `start` accepted at edge 0:
  - `load` is high in cycle 1; the counter captures `lo` at edge 1.
  - `q == hi` after edge 1+m.
- One sweep occupies 2m + PAUSE cycles. Each extra sweep adds PAUSE cycles for HOLD_BOT.
- `busy` lasts 2 + R·(2m + PAUSE) + (R−1)·PAUSE cycles for R sweeps. `done` is the last of these cycles.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `SWEEP_WATCHDOG_EN` defined:
  - A ⌈log2(2^N+2)⌉-bit counter counts consecutive cycles spent in RISE or FALL; it resets on every state change.
  - If it reaches 2^N+1 (counter stuck, or `q` never hits the target), set `err`, go straight to IDLE with `en = 0`, and do not pulse `done`.
- Not defined: no watchdog counter. `err` is only set by `lo > hi`, and RISE/FALL wait indefinitely.

## Test plan
- Reset, then `lo=3`, `hi=9`, `reps=1`, PAUSE=2, start at edge 0 → `load` in cycle 1 with `d=3`; `q` 3→9 by edge 7, held through edges 8–9, 9→3 by edge 15; `done` in cycle 16; `busy` 16 cycles.
- `lo=0`, `hi=15`, `reps=3` → three full triangles, `q` never wraps past 15 or below 0; HOLD_BOT appears exactly twice.
- `lo=hi=5`, `reps=2` → `q` stays 5; `en` never asserted; `done` after 2 + 2·2 + 2 = 8 busy cycles.
- `lo=10`, `hi=4` → `err=1`, `busy` stays 0. A following valid `start` clears `err`.
- `reset` asserted mid-RISE → next cycle `en=0`, `busy=0`. A later start runs normally.
- With `SWEEP_WATCHDOG_EN`: hold the counter's enable low externally during RISE → `err=1` and IDLE after 2^N+1 = 17 RISE cycles, with no `done`.
